// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
//   Instruction-fetch stage. Owns the PC and fetches 16-bit words from the
//   I-cache over a variable-latency valid/ready handshake. A response in the
//   same cycle as the request is a hit. Drives the IF/ID register and handles
//   hazard stalls, cache misses, branch/call/ret redirects and HLT.
//
//   Optional feature: define IFU_PERF_CNT_EN to add saturating performance
//   counters (perf_fetched, perf_miss_cyc). With the macro undefined those
//   ports and counters are absent and all other behaviour is identical.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   stall_if       hazard stall: hold PC and IF/ID
//   redirect_en    taken branch/call/ret from EX
//   redirect_pc    redirect target (word address)
//   icache_re      fetch request
//   icache_addr    fetch word address
//   icache_data    instruction word, valid when icache_rdy
//   icache_rdy     data valid for the current request
//   if_inst        IF/ID instruction
//   if_pc_plus1    IF/ID PC+1 of if_inst
//   if_valid       IF/ID holds a real instruction
//   halted         fetch stopped by HLT
//   perf_fetched   (IFU_PERF_CNT_EN) instructions captured, saturating
//   perf_miss_cyc  (IFU_PERF_CNT_EN) cycles spent in WAIT or DRAIN, saturating
// ---------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  HLT_OPC  = 4'b1111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_if,
    input  logic        redirect_en,
    input  logic [15:0] redirect_pc,
    output logic        icache_re,
    output logic [15:0] icache_addr,
    input  logic [15:0] icache_data,
    input  logic        icache_rdy,
    output logic [15:0] if_inst,
    output logic [15:0] if_pc_plus1,
    output logic        if_valid,
    output logic        halted
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [15:0] perf_fetched,
    output logic [15:0] perf_miss_cyc
`endif
);

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    logic [2:0]  state;
    logic [15:0] pc;
    logic [15:0] fetch_addr;
    logic [15:0] skid_word;

    logic [15:0] cur_addr;
    logic        capture;
    logic [15:0] cap_word;
    logic [15:0] cap_next_pc;

    // FETCH presents the PC directly so a hit completes in the request cycle;
    // every other state keeps the address of the request already in flight.
    // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        cur_addr  = (state == S_FETCH) ? pc : fetch_addr;
        icache_re = 1'b0;
        case (state)
            S_FETCH:         icache_re = ~stall_if;
            S_WAIT, S_DRAIN: icache_re = 1'b1;
            default:         icache_re = 1'b0;
        endcase

        // Capture happens on a hit/fill when not stalled, or from the skid
        // once a stall that blocked a fill has cleared.
        capture = 1'b0;
        if (!redirect_en && !stall_if) begin
            case (state)
                S_FETCH, S_WAIT: capture = icache_rdy;
                S_HOLD:          capture = 1'b1;
                default:         capture = 1'b0;
            endcase
        end
        cap_word    = (state == S_HOLD) ? skid_word : icache_data;
        cap_next_pc = cur_addr + 16'd1;  // modulo 2^16 wrap is intended
    end

    assign icache_addr = cur_addr;
    assign halted      = (state == S_HALT);

    // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            fetch_addr  <= RESET_PC;
            skid_word   <= 16'h0000;
            if_inst     <= 16'h0000;
            if_pc_plus1 <= 16'h0000;
            if_valid    <= 1'b0;
        end else if (redirect_en) begin
            // A request that is still outstanding cannot be cancelled, so
            // its response has to be absorbed in DRAIN before refetching.
            pc       <= redirect_pc;
            if_valid <= 1'b0;
            if ((state == S_WAIT || state == S_DRAIN) && !icache_rdy)
                state <= S_DRAIN;
            else
                state <= S_FETCH;
        end else if (capture) begin
            if_inst     <= cap_word;
            if_pc_plus1 <= cap_next_pc;
            if_valid    <= 1'b1;
            pc          <= cap_next_pc;
            if (state == S_FETCH)
                fetch_addr <= pc;
            state <= (cap_word[15:12] == HLT_OPC) ? S_HALT : S_FETCH;
        end else begin
            case (state)
                S_FETCH: begin
                    if (!stall_if) begin
                        fetch_addr <= pc;
                        if_valid   <= 1'b0;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (icache_rdy) begin
                        // Fill arrived under a stall: park it in the skid.
                        skid_word <= icache_data;
                        pc        <= fetch_addr + 16'd1;
                        state     <= S_HOLD;
                    end else if (!stall_if) begin
                        if_valid <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (icache_rdy)
                        state <= S_FETCH;
                end
                S_HALT: begin
                    if (!stall_if)
                        if_valid <= 1'b0;
                end
                default: ;  // S_HOLD under stall: everything held
            endcase
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched  <= 16'h0000;
            perf_miss_cyc <= 16'h0000;
        end else begin
            if (capture && perf_fetched != 16'hFFFF)
                perf_fetched <= perf_fetched + 16'd1;
            if ((state == S_WAIT || state == S_DRAIN) && perf_miss_cyc != 16'hFFFF)
                perf_miss_cyc <= perf_miss_cyc + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_if;
    logic        redirect_en;
    logic [15:0] redirect_pc;
    logic        icache_re;
    logic [15:0] icache_addr;
    logic [15:0] icache_data;
    logic        icache_rdy;
    logic [15:0] if_inst;
    logic [15:0] if_pc_plus1;
    logic        if_valid;
    logic        halted;
`ifdef IFU_PERF_CNT_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_miss_cyc;
`endif

    logic        rdy_en;
    logic [15:0] mem [0:255];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    // Simple I-cache model: data from a small table, readiness forced by bench.
    assign icache_data = mem[icache_addr[7:0]];
    assign icache_rdy  = rdy_en;

    inst_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_if    (stall_if),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .icache_re   (icache_re),
        .icache_addr (icache_addr),
        .icache_data (icache_data),
        .icache_rdy  (icache_rdy),
        .if_inst     (if_inst),
        .if_pc_plus1 (if_pc_plus1),
        .if_valid    (if_valid),
        .halted      (halted)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_miss_cyc (perf_miss_cyc)
`endif
    );

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ifid(input string tag, input logic [15:0] inst,
                        input logic [15:0] pcp1, input logic vld);
        check({tag, "_inst"}, if_inst, inst);
        check({tag, "_pcp1"}, if_pc_plus1, pcp1);
        check({tag, "_valid"}, {15'd0, if_valid}, {15'd0, vld});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
        mem[0] = 16'h1123;
        mem[1] = 16'h2456;
        mem[9] = 16'hF000;

        rst_n = 1'b0; stall_if = 1'b0; redirect_en = 1'b0; redirect_pc = 16'h0; rdy_en = 1'b1;
        step(); step();
        ifid("rst", 16'h0000, 16'h0000, 1'b0);
        check("rst_addr", icache_addr, 16'h0000);
        check("rst_re", {15'd0, icache_re}, 16'd1);
        check("rst_halted", {15'd0, halted}, 16'd0);

        // Streaming hits, one instruction per cycle
        rst_n = 1'b1;
        step(); ifid("hit0", 16'h1123, 16'h0001, 1'b1); check("hit0_addr", icache_addr, 16'h0001);
        step(); ifid("hit1", 16'h2456, 16'h0002, 1'b1); check("hit1_addr", icache_addr, 16'h0002);
        step(); ifid("hit2", 16'h1002, 16'h0003, 1'b1);
        step(); ifid("hit3", 16'h1003, 16'h0004, 1'b1); check("hit3_addr", icache_addr, 16'h0004);

        // Three-cycle miss at address 4
        rdy_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("miss_valid", {15'd0, if_valid}, 16'd0);
            check("miss_addr", icache_addr, 16'h0004);
            check("miss_re", {15'd0, icache_re}, 16'd1);
        end
        rdy_en = 1'b1;
        step(); ifid("fill4", 16'h1004, 16'h0005, 1'b1); check("fill4_addr", icache_addr, 16'h0005);

        // Miss at 5, fill arrives while stalled -> skid/HOLD
        rdy_en = 1'b0;
        step(); check("m5_valid", {15'd0, if_valid}, 16'd0);
        rdy_en = 1'b1; stall_if = 1'b1;
        step(); check("hold_re", {15'd0, icache_re}, 16'd0); check("hold_valid", {15'd0, if_valid}, 16'd0);
        step(); check("hold2_re", {15'd0, icache_re}, 16'd0);
        stall_if = 1'b0;
        step(); ifid("skid", 16'h1005, 16'h0006, 1'b1); check("skid_addr", icache_addr, 16'h0006);

        // Stall in FETCH holds IF/ID and suppresses the request
        stall_if = 1'b1; #1;
        check("stall_re", {15'd0, icache_re}, 16'd0);
        step(); ifid("stall", 16'h1005, 16'h0006, 1'b1); check("stall_addr", icache_addr, 16'h0006);
        stall_if = 1'b0;
        step(); ifid("post_stall", 16'h1006, 16'h0007, 1'b1);
        step(); ifid("hit7", 16'h1007, 16'h0008, 1'b1);

        // Redirect during miss at 8 -> DRAIN, stale data dropped
        rdy_en = 1'b0;
        step(); check("m8_valid", {15'd0, if_valid}, 16'd0);
        redirect_en = 1'b1; redirect_pc = 16'h0040;
        step(); redirect_en = 1'b0;
        check("drain_addr", icache_addr, 16'h0008);
        check("drain_re", {15'd0, icache_re}, 16'd1);
        check("drain_valid", {15'd0, if_valid}, 16'd0);
        step(); check("drain2_addr", icache_addr, 16'h0008);
        rdy_en = 1'b1;
        step(); ifid("drop", 16'h1007, 16'h0008, 1'b0); check("drop_addr", icache_addr, 16'h0040);
        step(); ifid("tgt40", 16'h1040, 16'h0041, 1'b1);

        // Redirect to 9 (HLT) with same-cycle hit dropped
        redirect_en = 1'b1; redirect_pc = 16'h0009;
        step(); redirect_en = 1'b0;
        ifid("rd9", 16'h1040, 16'h0041, 1'b0); check("rd9_addr", icache_addr, 16'h0009);
        step(); ifid("hlt", 16'hF000, 16'h000A, 1'b1);
        check("hlt_halted", {15'd0, halted}, 16'd1);
        check("hlt_re", {15'd0, icache_re}, 16'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("halt_valid", {15'd0, if_valid}, 16'd0);
            check("halt_re", {15'd0, icache_re}, 16'd0);
            check("halt_halted", {15'd0, halted}, 16'd1);
        end
        redirect_en = 1'b1; redirect_pc = 16'h0020;
        step(); redirect_en = 1'b0;
        check("resume_halted", {15'd0, halted}, 16'd0);
        check("resume_addr", icache_addr, 16'h0020);
        check("resume_re", {15'd0, icache_re}, 16'd1);
        step(); ifid("resume", 16'h1020, 16'h0021, 1'b1);

        // PC wrap at 0xFFFF
        redirect_en = 1'b1; redirect_pc = 16'hFFFF;
        step(); redirect_en = 1'b0;
        check("wrap_req", icache_addr, 16'hFFFF);
        step(); ifid("wrap", 16'h10FF, 16'h0000, 1'b1); check("wrap_addr", icache_addr, 16'h0000);

`ifdef IFU_PERF_CNT_EN
        check("perf_fetched", perf_fetched, 16'd12);
        check("perf_miss_cyc", perf_miss_cyc, 16'd7);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
